// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Definitions shared by the display source scheduler and its BCD converter:
//   - state_t     : scheduler state encoding (IDLE, CONVERT, PUBLISH, DWELL)
//   - DISP_MAX    : largest value the 4-digit display can show (9999)
//   - BIN_W       : binary operand width needed for DISP_MAX (14 bits)
//   - BCD_W       : packed BCD width for NUM_DIGITS digits (16 bits)
//   - VAL_W       : width of one requester value (32 bits)
//   - dd_adjust() : one double-dabble nibble correction (+3 when >= 5)
// -----------------------------------------------------------------------------
package display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_PUBLISH = 2'd2,
    ST_DWELL   = 2'd3
  } state_t;

  localparam int DISP_MAX   = 9999;
  localparam int BIN_W      = 14;
  localparam int BCD_W      = 16;
  localparam int NUM_DIGITS = 4;
  localparam int VAL_W      = 32;

  // A nibble of 5..9 would exceed 9 after doubling; pre-adding 3 makes the
  // following left shift carry correctly into the next decimal digit.
  function automatic logic [3:0] dd_adjust(input logic [3:0] nib);
    return (nib >= 4'd5) ? (nib + 4'd3) : nib;
  endfunction

endpackage

// File: rtl/display_source_scheduler_bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Iterative double-dabble converter, one iteration per clock, BIN_W iterations.
// Ports:
//   clk      : clock
//   rst_n    : asynchronous active-low reset
//   start    : one-cycle pulse; the start edge itself performs iteration 1
//   operand  : BIN_W-bit binary value, sampled on the start edge
//   done     : high during the cycle whose closing edge performs the final
//              iteration; bcd holds the complete result from the next cycle
//   bcd      : packed BCD result, NUM_DIGITS nibbles, ones in [3:0]
// -----------------------------------------------------------------------------
module bin2bcd_seq
  import display_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] operand,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  localparam logic [3:0] LAST_ITER = 4'(BIN_W - 1);

  logic [BCD_W-1:0]       r_bcd;
  logic [BIN_W-1:0]       r_bin;
  logic [3:0]             r_cnt;   // iterations already completed
  logic                   r_run;

  logic [BCD_W-1:0]       w_src_bcd;
  logic [BIN_W-1:0]       w_src_bin;
  logic [BCD_W-1:0]       w_adj_bcd;
  logic [BCD_W+BIN_W-1:0] w_shift;

  // On start the BCD accumulator is taken as zero, so the first iteration
  // can run on the start edge without a separate load cycle.
  assign w_src_bcd = start ? '0 : r_bcd;
  assign w_src_bin = start ? operand : r_bin;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adjust
      assign w_adj_bcd[4*gi +: 4] = dd_adjust(w_src_bcd[4*gi +: 4]);
    end
  endgenerate

  assign w_shift = {w_adj_bcd, w_src_bin} << 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcd <= '0;
      r_bin <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (start || r_run) begin
      r_bcd <= w_shift[BCD_W+BIN_W-1:BIN_W];
      r_bin <= w_shift[BIN_W-1:0];
      if (start) begin
        r_cnt <= 4'd1;
        r_run <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 4'd1;
        if (r_cnt == LAST_ITER) begin
          r_run <= 1'b0;
        end
      end
    end
  end

  assign done = r_run && (r_cnt == LAST_ITER);
  assign bcd  = r_bcd;

endmodule

// File: rtl/display_source_scheduler.sv
// -----------------------------------------------------------------------------
// display_source_scheduler
// Round-robin sharing of a 4-digit seven-segment display between NUM_SRC
// requesters. A granted 32-bit value is clamped to 9999, converted to BCD,
// published, and held for DWELL_CYCLES before the next requester is served.
// Ports:
//   clock_100Mhz : system clock
//   reset_n      : asynchronous active-low reset
//   req_valid    : per-source level request
//   req_value    : packed values, source i at [32*i +: 32]
//   hold         : freezes the dwell counter while high
//   req_grant    : one-hot pulse in the cycle whose closing edge samples the value
//   bcd_digits   : published BCD digits, thousands in [15:12]
//   disp_update  : one-cycle pulse after bcd_digits/disp_src/disp_ovf load
//   disp_src     : index of the displayed source
//   disp_ovf     : displayed value was clamped (original value > 9999)
//   busy         : high in CONVERT, PUBLISH and DWELL
// -----------------------------------------------------------------------------
module display_source_scheduler
  import display_pkg::*;
#(
  parameter int NUM_SRC      = 4,
  parameter int SRC_W        = $clog2(NUM_SRC),
  parameter int DWELL_CYCLES = 100000000,
  parameter int CNT_W        = 27
) (
  input  logic                     clock_100Mhz,
  input  logic                     reset_n,
  input  logic [NUM_SRC-1:0]       req_valid,
  input  logic [VAL_W*NUM_SRC-1:0] req_value,
  input  logic                     hold,
  output logic [NUM_SRC-1:0]       req_grant,
  output logic [BCD_W-1:0]         bcd_digits,
  output logic                     disp_update,
  output logic [SRC_W-1:0]         disp_src,
  output logic                     disp_ovf,
  output logic                     busy
);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

  state_t           r_state;
  logic [SRC_W-1:0] r_last;          // most recently granted source
  logic [VAL_W-1:0] r_value;
  logic             r_start;
  logic [CNT_W-1:0] r_cnt;
  logic [BCD_W-1:0] r_bcd_digits;
  logic             r_disp_update;
  logic [SRC_W-1:0] r_disp_src;
  logic             r_disp_ovf;
  logic             r_busy;

  logic             w_any;
  logic [SRC_W-1:0] w_idx;
  logic [SRC_W-1:0] w_cand;
  logic [NUM_SRC-1:0] w_grant;
  logic             w_ovf;
  logic [BIN_W-1:0] w_operand;
  logic             w_done;
  logic [BCD_W-1:0] w_bcd;

  // Round-robin search starting just after the last winner, so every
  // active requester is reached within NUM_SRC-1 periods.
  always_comb begin
    w_any  = 1'b0;
    w_idx  = '0;
    w_cand = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      w_cand = SRC_W'((int'(r_last) + k) % NUM_SRC);
      if (!w_any && req_valid[w_cand]) begin
        w_any = 1'b1;
        w_idx = w_cand;
      end
    end
  end

  // The grant is visible in the same IDLE cycle whose closing edge samples
  // the value; it is forced low while reset is applied.
  assign w_grant   = ((r_state == ST_IDLE) && w_any) ? (NUM_SRC'(1) << w_idx) : '0;
  assign req_grant = reset_n ? w_grant : '0;

  // Values beyond the display range show as 9999 with the overflow flag.
  assign w_ovf     = (r_value > VAL_W'(DISP_MAX));
  assign w_operand = w_ovf ? BIN_W'(DISP_MAX) : r_value[BIN_W-1:0];

  bin2bcd_seq u_bin2bcd (
    .clk     (clock_100Mhz),
    .rst_n   (reset_n),
    .start   (r_start),
    .operand (w_operand),
    .done    (w_done),
    .bcd     (w_bcd)
  );

  always_ff @(posedge clock_100Mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_last        <= SRC_W'(NUM_SRC - 1);
      r_value       <= '0;
      r_start       <= 1'b0;
      r_cnt         <= '0;
      r_bcd_digits  <= '0;
      r_disp_update <= 1'b0;
      r_disp_src    <= '0;
      r_disp_ovf    <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_start       <= 1'b0;
      r_disp_update <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_value <= req_value[VAL_W*w_idx +: VAL_W];
            r_last  <= w_idx;
            r_start <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= ST_CONVERT;
          end
        end
        ST_CONVERT: begin
          if (w_done) begin
            r_state <= ST_PUBLISH;
          end
        end
        ST_PUBLISH: begin
          r_bcd_digits  <= w_bcd;
          r_disp_src    <= r_last;
          r_disp_ovf    <= w_ovf;
          r_disp_update <= 1'b1;
          r_cnt         <= '0;
          r_state       <= ST_DWELL;
        end
        ST_DWELL: begin
          if (!hold) begin
            if (r_cnt == DWELL_LAST) begin
              r_cnt   <= '0;
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bcd_digits  = r_bcd_digits;
  assign disp_update = r_disp_update;
  assign disp_src    = r_disp_src;
  assign disp_ovf    = r_disp_ovf;
  assign busy        = r_busy;

endmodule

// File: tb/tb_display_source_scheduler.sv
module tb_display_source_scheduler;

  localparam int NUM_SRC = 4;
  localparam int SRC_W   = 2;
  localparam int DWELL   = 20;
  localparam int PERIOD  = DWELL + 16;

  logic                  clk;
  logic                  reset_n;
  logic [NUM_SRC-1:0]    req_valid;
  logic [32*NUM_SRC-1:0] req_value;
  logic                  hold;
  logic [NUM_SRC-1:0]    req_grant;
  logic [15:0]           bcd_digits;
  logic                  disp_update;
  logic [SRC_W-1:0]      disp_src;
  logic                  disp_ovf;
  logic                  busy;

  display_source_scheduler #(
    .NUM_SRC      (NUM_SRC),
    .SRC_W        (SRC_W),
    .DWELL_CYCLES (DWELL),
    .CNT_W        (8)
  ) dut (
    .clock_100Mhz (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_value    (req_value),
    .hold         (hold),
    .req_grant    (req_grant),
    .bcd_digits   (bcd_digits),
    .disp_update  (disp_update),
    .disp_src     (disp_src),
    .disp_ovf     (disp_ovf),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  task automatic fail_now(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    int          src;
    logic [15:0] bcd;
    logic        ovf;
    int          e0;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int               grant_count = 0;
  int               upd_count   = 0;
  logic [NUM_SRC-1:0] last_grant_vec = '0;
  int               last_grant_cyc = 0;

  always @(negedge clk) begin
    if (req_grant != '0) begin
      grant_count++;
      last_grant_vec = req_grant;
      last_grant_cyc = cyc;
    end
    if (disp_update) begin
      upd_count++;
      $display("update cyc=%0d src=%0d bcd=%h ovf=%0d", cyc, disp_src, bcd_digits, disp_ovf);
      if (sb.size() == 0) begin
        fail_now("unexpected_update", 32'(bcd_digits), 32'hFFFF_FFFF);
      end else begin
        mon_e = sb.pop_front();
        check("upd_bcd", 32'(bcd_digits), 32'(mon_e.bcd));
        check("upd_src", 32'(disp_src), 32'(mon_e.src));
        check("upd_ovf", 32'(disp_ovf), 32'(mon_e.ovf));
        check("upd_latency", 32'(cyc - mon_e.e0), 32'd15);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_grant(input int exp_src, input logic [15:0] exp_bcd, input logic exp_ovf,
                            input bit push, output int gcyc);
    int start_cnt;
    int n;
    exp_t e;
    start_cnt = grant_count;
    n = 0;
    gcyc = 0;
    while (grant_count == start_cnt && n < 200) begin
      step(1);
      n++;
    end
    if (grant_count == start_cnt) begin
      fail_now("grant_timeout", 32'd0, 32'(exp_src));
    end else begin
      check("grant_vec", 32'(last_grant_vec), 32'(1) << exp_src);
      gcyc = last_grant_cyc;
      if (push) begin
        e.src = exp_src;
        e.bcd = exp_bcd;
        e.ovf = exp_ovf;
        e.e0  = last_grant_cyc + 1;
        sb.push_back(e);
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin
      step(1);
      n++;
    end
    if (busy) fail_now("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic set_value(input int src, input logic [31:0] v);
    req_value[32*src +: 32] = v;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant"},  32'(req_grant),   32'd0);
    check({tag, "_bcd"},    32'(bcd_digits),  32'd0);
    check({tag, "_update"}, 32'(disp_update), 32'd0);
    check({tag, "_src"},    32'(disp_src),    32'd0);
    check({tag, "_ovf"},    32'(disp_ovf),    32'd0);
    check({tag, "_busy"},   32'(busy),        32'd0);
  endtask

  // ---------------- table of single-source transactions ----------------
  typedef struct {
    int          src;
    logic [31:0] value;
    logic [15:0] bcd;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int g1, g2, g3, gc0, uc0;

    vecs[0] = '{src: 1, value: 32'd1234,       bcd: 16'h1234, ovf: 1'b0};
    vecs[1] = '{src: 3, value: 32'd12345,      bcd: 16'h9999, ovf: 1'b1};
    vecs[2] = '{src: 3, value: 32'd0,          bcd: 16'h0000, ovf: 1'b0};
    vecs[3] = '{src: 2, value: 32'd9999,       bcd: 16'h9999, ovf: 1'b0};
    vecs[4] = '{src: 0, value: 32'd10000,      bcd: 16'h9999, ovf: 1'b1};
    vecs[5] = '{src: 1, value: 32'd5,          bcd: 16'h0005, ovf: 1'b0};
    vecs[6] = '{src: 2, value: 32'hFFFF_FFFF,  bcd: 16'h9999, ovf: 1'b1};
    vecs[7] = '{src: 0, value: 32'd8421,       bcd: 16'h8421, ovf: 1'b0};

    reset_n   = 1'b0;
    req_valid = '0;
    req_value = '0;
    hold      = 1'b0;
    step(3);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    step(2);

    // Table-driven: one requester at a time, request dropped after grant.
    for (int i = 0; i < 8; i++) begin
      set_value(vecs[i].src, vecs[i].value);
      req_valid = NUM_SRC'(1) << vecs[i].src;
      wait_grant(vecs[i].src, vecs[i].bcd, vecs[i].ovf, 1'b1, g1);
      req_valid = '0;
      wait_idle();
    end

    // Single persistent requester: re-granted every period.
    set_value(1, 32'd1234);
    req_valid = 4'b0010;
    wait_grant(1, 16'h1234, 1'b0, 1'b1, g1);
    wait_grant(1, 16'h1234, 1'b0, 1'b1, g2);
    check("regrant_gap", 32'(g2 - g1), 32'(PERIOD));
    req_valid = '0;
    wait_idle();

    // No requests: no grant, no update, digits held.
    gc0 = grant_count;
    uc0 = upd_count;
    step(100);
    check("idle_no_grant",  32'(grant_count - gc0), 32'd0);
    check("idle_no_update", 32'(upd_count - uc0),   32'd0);
    check("idle_bcd_held",  32'(bcd_digits),        32'h1234);

    // Two requesters alternate after a pointer reset.
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    set_value(0, 32'd42);
    set_value(2, 32'd9999);
    req_valid = 4'b0101;
    wait_grant(0, 16'h0042, 1'b0, 1'b1, g1);
    wait_grant(2, 16'h9999, 1'b0, 1'b1, g2);
    wait_grant(0, 16'h0042, 1'b0, 1'b1, g3);
    check("rr_gap_1", 32'(g2 - g1), 32'(PERIOD));
    check("rr_gap_2", 32'(g3 - g2), 32'(PERIOD));
    req_valid = '0;
    wait_idle();

    // hold in DWELL delays the next grant; hold in CONVERT does not.
    set_value(1, 32'd77);
    req_valid = 4'b0010;
    wait_grant(1, 16'h0077, 1'b0, 1'b1, g1);
    step(17);
    hold = 1'b1;
    step(10);
    hold = 1'b0;
    wait_grant(1, 16'h0077, 1'b0, 1'b1, g2);
    check("hold_dwell_gap", 32'(g2 - g1), 32'(PERIOD + 10));
    hold = 1'b1;
    step(10);
    hold = 1'b0;
    wait_grant(1, 16'h0077, 1'b0, 1'b1, g3);
    check("hold_convert_gap", 32'(g3 - g2), 32'(PERIOD));
    req_valid = '0;
    wait_idle();

    // Reset in cycle 7 of CONVERT aborts; pointer restarts at source 0.
    set_value(2, 32'd555);
    set_value(3, 32'd4000);
    req_valid = 4'b1100;
    wait_grant(2, 16'h0555, 1'b0, 1'b0, g1);
    step(6);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    set_value(0, 32'd321);
    req_valid = 4'b1001;
    step(2);
    reset_n = 1'b1;
    wait_grant(0, 16'h0321, 1'b0, 1'b1, g1);
    wait_grant(3, 16'h4000, 1'b0, 1'b1, g2);
    check("post_reset_gap", 32'(g2 - g1), 32'(PERIOD));
    req_valid = '0;
    wait_idle();
    step(5);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/display_source_scheduler.md
Name: display_source_scheduler

Overview:
Shares the 4-digit seven-segment display between up to NUM_SRC requesters (ALU result, PC, debug registers, and similar sources).
- Selects one requesting source at a time by round-robin.
- Latches its 32-bit value and converts it to four BCD digits with a sequential double-dabble.
- Holds the published digits for a dwell period, then moves on to the next requester.
- Its outputs feed the display multiplexer's digit inputs directly, with no division logic downstream.

Parameters:
NUM_SRC, 4, number of requesters (2..8)
SRC_W, 2, width of source index, equal to clog2(NUM_SRC)
DWELL_CYCLES, 100000000, cycles each published value is held (1 s at 100 MHz)
CNT_W, 27, dwell counter width; must hold DWELL_CYCLES

Ports:
clock_100Mhz  input  1  system clock, 100 MHz
reset_n  input  1  asynchronous, active-low reset
req_valid  input  NUM_SRC  per-source request, level-sensitive
req_value  input  32*NUM_SRC  packed values; source i occupies [32*i+31:32*i]
hold  input  1  freezes the dwell counter while high
req_grant  output  NUM_SRC  one-hot, one-cycle pulse on the cycle the granted value is sampled
bcd_digits  output  16  [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] ones
disp_update  output  1  one-cycle pulse when bcd_digits/disp_src/disp_ovf change
disp_src  output  SRC_W  index of the source currently displayed
disp_ovf  output  1  high when the displayed value exceeded 9999
busy  output  1  high in CONVERT, PUBLISH and DWELL

Behaviour:
- Reset values: req_grant=0, bcd_digits=0, disp_update=0, disp_src=0, disp_ovf=0, busy=0, state=IDLE, rr pointer last=NUM_SRC-1 (source 0 wins first).
- Reset asserted mid-operation aborts any conversion or dwell immediately; all outputs and state take reset values.
- State machine: IDLE -> CONVERT -> PUBLISH -> DWELL -> IDLE.
- IDLE, no req_valid bit set: stay in IDLE; display outputs retain their last values.
- IDLE, any req_valid bit set:
  - Grant the first set bit searching last+1, last+2, ... modulo NUM_SRC.
  - req_grant pulses for that cycle; the value is latched on the same edge (edge E0); last <= granted index; go to CONVERT.
- Overflow clamp: if latched value >= 10000, the conversion operand is 9999 and ovf_pending=1. Otherwise the operand is value[13:0] and ovf_pending=0.
- CONVERT: 14 iterations of double-dabble, one per cycle (edges E1..E14). In each iteration, add 3 to any BCD nibble >= 5, then shift left by 1. Then go to PUBLISH.
- PUBLISH: one cycle. On edge E15, bcd_digits, disp_src and disp_ovf load, and disp_update=1 for the following cycle only. Go to DWELL.
- Latency: sample edge to disp_update high is 15 cycles.
- DWELL: counter counts 0..DWELL_CYCLES-1 and advances only while hold=0. At terminal count, go to IDLE.
  - Period per source with hold=0 is DWELL_CYCLES+16 cycles (1 IDLE + 14 CONVERT + 1 PUBLISH + DWELL_CYCLES).
- Single requester: it is re-granted every period, so its displayed value refreshes each period. disp_update pulses even when the value is unchanged.
- Input timing:
  - req_valid or req_value changing after the grant edge has no effect on the current cycle.
  - A request that drops before IDLE is simply skipped.
  - A request appearing during DWELL waits for the next IDLE.
- hold during CONVERT/PUBLISH has no effect; it only freezes the DWELL counter.
- Simultaneous requests are resolved by the round-robin pointer only; no source starves. Worst-case wait is (NUM_SRC-1) periods.

Decomposition:
- Shared package (display_pkg): state encoding (IDLE, CONVERT, PUBLISH, DWELL), DISP_MAX=9999, BIN_W=14, BCD_W=16, NUM_DIGITS=4.
- Sub-module bin2bcd_seq: start/operand[13:0] in, done/bcd[15:0] out, 14-cycle iterative double-dabble. The scheduler owns arbitration, clamp, publish and dwell.

Test Plan:
1. DWELL_CYCLES=20; only src1 valid with 1234 -> req_grant=4'b0010 for one cycle; 15 cycles later disp_update pulses with bcd_digits=16'h1234, disp_src=1, disp_ovf=0; re-grant 36 cycles after the first.
2. src0=42, src2=9999 both valid -> sequence src0 (16'h0042), src2 (16'h9999, ovf=0), src0 ..., with grants spaced 36 cycles apart.
3. src3=12345 -> bcd_digits=16'h9999, disp_ovf=1. Then src3=0 -> 16'h0000, disp_ovf=0.
4. hold=1 for 10 cycles during DWELL -> next grant delayed by exactly 10 cycles. hold during CONVERT -> no delay.
5. Assert reset_n=0 at cycle 7 of CONVERT -> outputs return to reset values immediately. After release with src0 valid, src0 is granted first.
6. All req_valid=0 after one publish -> no grant, no disp_update; bcd_digits holds its last value indefinitely.
